// File: rtl/pwm_duty_generator_if.sv
// PWM generator bundle: run/duty controls in, waveform and status out.
// master drives the controls, slave is the generator.
interface pwm_duty_generator_if;
  logic        en;
  logic [11:0] duty_in;
  logic        duty_load;
  logic        pwm_out;
  logic        period_tick;
  logic [11:0] duty_active;
  logic        busy;

  modport master (
    output en, duty_in, duty_load,
    input  pwm_out, period_tick, duty_active, busy
  );

  modport slave (
    input  en, duty_in, duty_load,
    output pwm_out, period_tick, duty_active, busy
  );
endinterface

// File: rtl/pwm_duty_generator.sv
// Fixed-period PWM with double-buffered duty and gated run/stop.
// Optional PWM_SOFTSTART_EN ramps duty_active by STEP per period.
module pwm_duty_generator #(
  parameter int PERIOD = 500,
  parameter int STEP   = 10
) (
  input  logic clk,
  input  logic rst,
  pwm_duty_generator_if.slave bus
);
  localparam logic [11:0] PMAX = 12'(PERIOD);
  localparam logic [11:0] LAST = 12'(PERIOD - 1);

  if (PERIOD < 2 || PERIOD > 4095 || STEP < 1) begin : g_bad_cfg
    $error("pwm_duty_generator: bad PERIOD/STEP");
  end

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  state_t      state, nstate;
  logic [11:0] cnt, ncnt;
  logic [11:0] pending;
  logic [11:0] duty, nduty;
  logic        pwm, npwm;
  logic        tick, ntick;
  logic [11:0] clamped, target;
  logic        load, wrap;

`ifdef PWM_SOFTSTART_EN
  localparam logic [11:0] STEPW = 12'(STEP);
  logic [11:0] base, diff, delta, ramp;
  logic        up;
`endif

  // next state, counter, boundary duty load and registered outputs
  always_comb begin
    nstate  = state;
    ncnt    = cnt;
    load    = 1'b0;
    clamped = (bus.duty_in > PMAX) ? PMAX : bus.duty_in;
    target  = bus.duty_load ? clamped : pending;
    wrap    = (cnt == LAST);
    unique case (state)
      IDLE: begin
        ncnt = '0;
        if (bus.en) begin
          nstate = RUN;
          load   = 1'b1;
        end
      end
      RUN: begin
        ncnt = wrap ? 12'd0 : cnt + 12'd1;
        load = wrap;
        if (!bus.en) nstate = STOP;
      end
      STOP: begin
        ncnt = wrap ? 12'd0 : cnt + 12'd1;
        if (bus.en) begin
          nstate = RUN;
          load   = wrap;
        end else if (wrap) begin
          nstate = IDLE;
        end
      end
      default: begin
        nstate = IDLE;
        ncnt   = '0;
      end
    endcase
`ifdef PWM_SOFTSTART_EN
    base  = (state == IDLE) ? 12'd0 : duty;
    up    = (target > base);
    diff  = up ? target - base : base - target;
    delta = (diff > STEPW) ? STEPW : diff;
    ramp  = up ? base + delta : base - delta;
    nduty = load ? ramp : duty;
`else
    nduty = load ? target : duty;
`endif
    npwm  = (nstate != IDLE) && (ncnt < nduty);
    ntick = (nstate != IDLE) && (ncnt == 12'd0);
  end

  // state, counter, duty buffers and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      pending <= '0;
      duty    <= '0;
      pwm     <= 1'b0;
      tick    <= 1'b0;
    end else begin
      state <= nstate;
      cnt   <= ncnt;
      duty  <= nduty;
      pwm   <= npwm;
      tick  <= ntick;
      if (bus.duty_load) pending <= clamped;
    end
  end

  assign bus.pwm_out     = pwm;
  assign bus.period_tick = tick;
  assign bus.duty_active = duty;
  assign bus.busy        = (state != IDLE);
endmodule

// File: tb/tb_pwm_duty_generator.sv
// Directed bench for pwm_duty_generator with PERIOD=10, STEP=3.
// Build with PWM_SOFTSTART_EN defined to exercise the ramp.
module tb_pwm_duty_generator;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  pwm_duty_generator_if bus ();

  pwm_duty_generator #(.PERIOD(10), .STEP(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] pat_of(input int d);
    logic [9:0] p;
    p = '0;
    for (int i = 0; i < 10; i++)
      if (i < d) p[9-i] = 1'b1;
    return p;
  endfunction

  // Sample one period from its cnt==0 cycle, MSB first.
  // Optional load at cycle ld_at and en drop/raise at off_at/on_at.
  task automatic grab(output logic [9:0] pat, output int ticks,
                      input int ld_at, input int ld_val,
                      input int off_at, input int on_at);
    pat = '0;
    ticks = 0;
    for (int i = 0; i < 10; i++) begin
      pat = {pat[8:0], bus.pwm_out};
      if (bus.period_tick === 1'b1) ticks++;
      if (i == ld_at) begin
        bus.duty_in = 12'(ld_val);
        bus.duty_load = 1'b1;
      end
      if (i == off_at) bus.en = 1'b0;
      if (i == on_at) bus.en = 1'b1;
      step();
      bus.duty_load = 1'b0;
    end
  endtask

  task automatic period(input string tag, input int d,
                        input int ld_at, input int ld_val,
                        input int off_at, input int on_at);
    logic [9:0] p;
    int t;
    grab(p, t, ld_at, ld_val, off_at, on_at);
    chk({tag, "_pat"}, 32'(p), 32'(pat_of(d)));
    chk({tag, "_tick"}, t, 1);
  endtask

  initial begin
    rst = 1'b1;
    bus.en = 1'b0;
    bus.duty_in = '0;
    bus.duty_load = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    chk("rst_pwm", 32'(bus.pwm_out), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_duty", 32'(bus.duty_active), 0);
    chk("rst_tick", 32'(bus.period_tick), 0);

`ifdef PWM_SOFTSTART_EN
    bus.en = 1'b1;
    bus.duty_in = 12'd8;
    bus.duty_load = 1'b1;
    step();
    bus.duty_load = 1'b0;
    chk("ss_first", 32'(bus.duty_active), 3);
    period("ss_3", 3, -1, 0, -1, -1);
    period("ss_6", 6, -1, 0, -1, -1);
    period("ss_8a", 8, -1, 0, -1, -1);
    period("ss_8b", 8, 0, 0, -1, -1);
    period("ss_5", 5, -1, 0, -1, -1);
    period("ss_2", 2, -1, 0, -1, -1);
    period("ss_0", 0, -1, 0, -1, -1);
    chk("ss_end", 32'(bus.duty_active), 0);
`else
    bus.en = 1'b1;
    bus.duty_in = 12'd4;
    bus.duty_load = 1'b1;
    step();
    bus.duty_load = 1'b0;
    chk("start_tick", 32'(bus.period_tick), 1);
    chk("start_busy", 32'(bus.busy), 1);
    chk("start_duty", 32'(bus.duty_active), 4);
    period("d4_p1", 4, -1, 0, -1, -1);
    period("d4_p2", 4, -1, 0, -1, -1);

    period("d4_p3", 4, 0, 4000, -1, -1);
    chk("clamp_duty", 32'(bus.duty_active), 10);
    period("d10_p1", 10, -1, 0, -1, -1);
    repeat (9) step();
    chk("d10_cnt9", 32'(bus.pwm_out), 1);
    bus.duty_in = 12'd0;
    bus.duty_load = 1'b1;
    step();
    bus.duty_load = 1'b0;
    chk("d0_duty", 32'(bus.duty_active), 0);
    chk("d0_first", 32'(bus.pwm_out), 0);
    period("d0_p1", 0, 0, 2, -1, -1);

    period("d2_mid7", 2, 3, 7, -1, -1);
    period("d7_byp5", 7, 9, 5, -1, -1);
    period("d5", 5, 0, 6, -1, -1);

    period("d6_stop", 6, 2, 6, 2, -1);
    chk("stop_busy", 32'(bus.busy), 0);
    chk("stop_pwm", 32'(bus.pwm_out), 0);
    chk("stop_tick", 32'(bus.period_tick), 0);
    chk("stop_duty", 32'(bus.duty_active), 6);
    step();
    chk("idle_pwm", 32'(bus.pwm_out), 0);

    bus.en = 1'b1;
    step();
    period("d6_rearm", 6, -1, 0, 2, 8);
    chk("rearm_busy", 32'(bus.busy), 1);
    period("d6_after", 6, -1, 0, -1, -1);

    step();
    chk("pre_rst_pwm", 32'(bus.pwm_out), 1);
    rst = 1'b1;
    bus.en = 1'b0;
    step();
    chk("mid_rst_pwm", 32'(bus.pwm_out), 0);
    chk("mid_rst_busy", 32'(bus.busy), 0);
    chk("mid_rst_duty", 32'(bus.duty_active), 0);
    chk("mid_rst_tick", 32'(bus.period_tick), 0);
    rst = 1'b0;
    step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
